instr_fetch_unit: RTL

//  Front-end stage feeding control_unit: owns the PC, fetches 16-bit words from instruction memory
//  via a req/resp handshake, buffers up to DEPTH decoded words, presents OPCODE/IMM/InstrPC to control_unit.

---
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word fetch at a time,
// buffers returned words in a small FIFO and presents the head instruction
// (opcode, immediate, PC, illegal flag) to the control unit. A redirect
// flushes the FIFO and discards any response still in flight.
module instr_fetch_unit #(
   parameter int unsigned          ADDR_W   = 16,
   parameter int unsigned          INSTR_W  = 16,
   parameter int unsigned          OPC_W    = 6,
   parameter int unsigned          DEPTH    = 2,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0,
   parameter int unsigned          MAX_OPC  = 39
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   output logic                     MemReqValid,
   output logic [ADDR_W-1:0]        MemReqAddr,
   input  logic                     MemReqReady,
   input  logic                     MemRespValid,
   input  logic [INSTR_W-1:0]       MemRespData,
   input  logic                     Redirect,
   input  logic [ADDR_W-1:0]        RedirectAddr,
   output logic                     InstrValid,
   input  logic                     InstrReady,
   output logic [OPC_W-1:0]         OPCODE,
   output logic [INSTR_W-OPC_W-1:0] IMM,
   output logic [ADDR_W-1:0]        InstrPC,
   output logic                     IllegalOp
);

   localparam int unsigned IMM_W = INSTR_W - OPC_W;
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] word;
      logic [ADDR_W-1:0]  pc;
      logic               ill;
   } entry_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   infl_pc_q;
   logic [PTR_W-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   entry_t              fifo_q [DEPTH];
   entry_t              new_ent, head_d;

   logic                req_vld_q, ivld_q, ill_q;
   logic [ADDR_W-1:0]   req_addr_q, ipc_q;
   logic [OPC_W-1:0]    opc_q;
   logic [IMM_W-1:0]    imm_q;

   logic accept, pop, push, outst_after;

   assign MemReqValid = req_vld_q;
   assign MemReqAddr  = req_addr_q;
   assign InstrValid  = ivld_q;
   assign OPCODE      = opc_q;
   assign IMM         = imm_q;
   assign InstrPC     = ipc_q;
   assign IllegalOp   = ill_q;

   // Next-state: handshakes, FIFO bookkeeping, FSM transitions and next head.
   always_comb begin
      accept  = req_vld_q && MemReqReady;
      pop     = ivld_q && InstrReady;
      push    = (state_q == S_WAIT) && MemRespValid && !Redirect;
      new_ent = '{word: MemRespData, pc: infl_pc_q,
                  ill: (MemRespData[INSTR_W-1 -: OPC_W] > OPC_W'(MAX_OPC))};
      state_d = state_q;
      pc_d    = pc_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      // A request is still in flight after this edge if one was just accepted
      // or if WAIT/DROP did not see its response this cycle.
      outst_after = accept ||
                    (((state_q == S_WAIT) || (state_q == S_DROP)) && !MemRespValid);
      if (Redirect) begin
         rd_d    = '0;
         wr_d    = '0;
         cnt_d   = '0;
         pc_d    = RedirectAddr;
         state_d = outst_after ? S_DROP : S_REQ;
      end else begin
         if (push) wr_d = wr_q + PTR_W'(1);
         if (pop)  rd_d = rd_q + PTR_W'(1);
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
         case (state_q)
            S_REQ:  if (accept) begin
                       pc_d    = pc_q + ADDR_W'(1);
                       state_d = S_WAIT;
                    end
            S_WAIT: if (MemRespValid)
                       state_d = (cnt_d < CNT_W'(DEPTH)) ? S_REQ : S_HOLD;
            S_HOLD: if (pop) state_d = S_REQ;
            S_DROP: if (MemRespValid) state_d = S_REQ;
            default: state_d = S_REQ;
         endcase
      end
      // A word pushed into an otherwise empty FIFO becomes the head immediately.
      head_d = (push && (rd_d == wr_q)) ? new_ent : fifo_q[rd_d];
   end

   // State, pointers and registered outputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         infl_pc_q  <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
         cnt_q      <= '0;
         req_vld_q  <= 1'b0;
         req_addr_q <= RESET_PC;
         ivld_q     <= 1'b0;
         opc_q      <= '0;
         imm_q      <= '0;
         ipc_q      <= '0;
         ill_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         cnt_q      <= cnt_d;
         if (accept) infl_pc_q <= pc_q;
         req_vld_q  <= (state_d == S_REQ);
         req_addr_q <= pc_d;
         ivld_q     <= (cnt_d != '0);
         opc_q      <= (cnt_d != '0) ? head_d.word[INSTR_W-1 -: OPC_W] : '0;
         imm_q      <= (cnt_d != '0) ? head_d.word[IMM_W-1:0] : '0;
         ipc_q      <= (cnt_d != '0) ? head_d.pc : '0;
         ill_q      <= (cnt_d != '0) ? head_d.ill : 1'b0;
      end
   end

   // FIFO storage; no reset needed since count qualifies every read.
   always_ff @(posedge CLK) begin
      if (push) fifo_q[wr_q] <= new_ent;
   end

   // Fetch is gated on free space, so a push into a full FIFO is a design bug.
   always_ff @(posedge CLK) begin
      if (RESET_N) assert (!(push && (cnt_q == CNT_W'(DEPTH))));
   end

endmodule
